// File: rtl/ripple_count_capture_if.sv
// Report channel of ripple_count_capture: accumulator snapshot plus coalesced delta.
// Single-beat valid/ready record; the master holds the payload until out_ready completes the handshake.
interface ripple_count_capture_if #(
   parameter int ACC_W = 16
);
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [ACC_W-1:0] out_delta;

   modport master (output out_valid, output out_data, output out_delta, input out_ready);
   modport slave  (input out_valid, input out_data, input out_delta, output out_ready);
endinterface

// File: rtl/ripple_count_capture.sv
// Syncs and de-glitches a 4-bit ripple count, accumulates mod-16 deltas; out_valid 2+STABLE_CYCLES clks after a stable input.
// Stalled records coalesce further deltas (never dropped); RCC_CAPTURE_OVF_EN adds a sticky acc_ovf output.
module ripple_count_capture #(
   parameter int ACC_W         = 16,
   parameter int STABLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             cnt_in,
   ripple_count_capture_if.master rpt
`ifdef RCC_CAPTURE_OVF_EN
   ,
   output logic                   acc_ovf
`endif
);
   localparam int RUN_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   logic [3:0]       s1, s2, last_acc;
   logic [RUN_W-1:0] run;
   logic [ACC_W-1:0] acc, pend_delta, out_data, out_delta;
   logic             pend;

   logic             accept;
   logic [3:0]       delta4;
   logic [ACC_W-1:0] delta, acc_nxt, pend_sum;

   assign accept = (run == RUN_MAX) && (s2 != last_acc);
   assign delta4 = s2 - last_acc;
   assign delta  = accept ? {{(ACC_W-4){1'b0}}, delta4} : '0;
   // With no accept these collapse to acc / pend_delta, so one load path serves both.
   assign pend_sum = pend_delta + delta;

`ifdef RCC_CAPTURE_OVF_EN
   logic acc_cy;
   logic ovf_q;
   assign {acc_cy, acc_nxt} = {1'b0, acc} + {1'b0, delta};
   assign acc_ovf = ovf_q;

   always_ff @(posedge clk) begin
      if (!reset)
         ovf_q <= 1'b0;
      else if (acc_cy)
         ovf_q <= 1'b1;
   end
`else
   assign acc_nxt = acc + delta;
`endif

   assign rpt.out_valid = (state == SEND);
   assign rpt.out_data  = out_data;
   assign rpt.out_delta = out_delta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         s1         <= '0;
         s2         <= '0;
         run        <= '0;
         last_acc   <= '0;
         acc        <= '0;
         pend_delta <= '0;
         pend       <= 1'b0;
         out_data   <= '0;
         out_delta  <= '0;
      end else begin
         s1 <= cnt_in;
         s2 <= s1;
         // s1 != s2 means s2 changes on this edge, restarting its stability run.
         if (s1 != s2)
            run <= RUN_W'(1);
         else if (run != RUN_MAX)
            run <= run + RUN_W'(1);

         if (accept) begin
            last_acc <= s2;
            acc      <= acc_nxt;
         end

         case (state)
            IDLE: begin
               if (accept || pend) begin
                  out_data   <= acc_nxt;
                  out_delta  <= pend_sum;
                  pend_delta <= '0;
                  pend       <= 1'b0;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (!rpt.out_ready) begin
                  if (accept) begin
                     pend_delta <= pend_sum;
                     pend       <= 1'b1;
                  end
               end else if (accept || pend) begin
                  out_data   <= acc_nxt;
                  out_delta  <= pend_sum;
                  pend_delta <= '0;
                  pend       <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench: 16-bit and 5-bit accumulator instances share one stimulus stream; records are checked on handshake.
`timescale 1ns/1ps
module tb_ripple_count_capture;
   typedef struct packed {
      logic [15:0] data;
      logic [15:0] delta;
   } rec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] cnt_in = 4'hA;
   logic       ready = 1'b1;
   int         n_cmp = 0;
   int         n_bad = 0;
   rec_t       exp_q[$];

   ripple_count_capture_if #(.ACC_W(16)) bus ();
   ripple_count_capture_if #(.ACC_W(5))  bus5 ();
   assign bus.out_ready  = ready;
   assign bus5.out_ready = ready;

`ifdef RCC_CAPTURE_OVF_EN
   logic ovf16, ovf5;
`endif

   ripple_count_capture #(.ACC_W(16), .STABLE_CYCLES(2)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .cnt_in (cnt_in),
      .rpt    (bus)
`ifdef RCC_CAPTURE_OVF_EN
      ,
      .acc_ovf(ovf16)
`endif
   );

   ripple_count_capture #(.ACC_W(5), .STABLE_CYCLES(2)) u_dut5 (
      .clk    (clk),
      .reset  (reset),
      .cnt_in (cnt_in),
      .rpt    (bus5)
`ifdef RCC_CAPTURE_OVF_EN
      ,
      .acc_ovf(ovf5)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input int d, input int dl);
      rec_t r;
      r.data  = 16'(d);
      r.delta = 16'(dl);
      exp_q.push_back(r);
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!bus.out_valid && k < 20) begin
         cyc(1);
         k++;
      end
      chk(name, 32'(bus.out_valid), 32'd1);
   endtask

   // Monitor: a handshake completes on the next posedge whenever both are high here.
   always @(negedge clk) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_record", 32'(bus.out_data), 32'hFFFF_FFFF);
         end else begin
            rec_t e;
            logic [4:0] d5, dl5;
            e   = exp_q.pop_front();
            d5  = e.data[4:0];
            dl5 = e.delta[4:0];
            chk("sb_data",     32'(bus.out_data),   32'(e.data));
            chk("sb_delta",    32'(bus.out_delta),  32'(e.delta));
            chk("sb5_valid",   32'(bus5.out_valid), 32'd1);
            chk("sb5_data",    32'(bus5.out_data),  32'(d5));
            chk("sb5_delta",   32'(bus5.out_delta), 32'(dl5));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      // Reset held with a nonzero input: everything stays cleared.
      cyc(3);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  32'(bus.out_data),  32'd0);
      chk("rst_delta", 32'(bus.out_delta), 32'd0);
      chk("rst5_data", 32'(bus5.out_data), 32'd0);
      push(10, 10);
      reset = 1'b1;
      cyc(3);
      chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
      cyc(1);
      chk("lat_e4_valid", 32'(bus.out_valid), 32'd1);
      cyc(1);
      chk("rst_rec_pulse", 32'(bus.out_valid), 32'd0);

      // Wrap delta: 10 -> 14 (+4), then 14 -> 2 (+4 mod 16).
      cnt_in = 4'd14; push(14, 4);
      wait_valid("wv_14");
      cyc(1);
      cnt_in = 4'd2; push(18, 4);
      wait_valid("wv_wrap");
      cyc(1);
      chk("wrap_pulse", 32'(bus.out_valid), 32'd0);

      // Glitch: 2 -> 7, then one clk of F before 8; only +1 may be reported.
      cnt_in = 4'd7; push(23, 5);
      wait_valid("wv_7");
      cyc(1);
      cnt_in = 4'hF;
      cyc(1);
      cnt_in = 4'd8; push(24, 1);
      wait_valid("wv_glitch");
      cyc(1);
      cyc(6);
      chk("glitch_no_extra", 32'(bus.out_valid), 32'd0);

      // 8 -> 0 is +8: acc 32, the 5-bit instance wraps to 0.
`ifdef RCC_CAPTURE_OVF_EN
      chk("ovf5_pre", 32'(ovf5), 32'd0);
`endif
      cnt_in = 4'd0; push(32, 8);
      wait_valid("wv_0");
`ifdef RCC_CAPTURE_OVF_EN
      chk("ovf5_set",  32'(ovf5),  32'd1);
      chk("ovf16_clr", 32'(ovf16), 32'd0);
`endif
      cyc(1);

      // Backpressure: +3 held, +2 coalesced, reload without a valid gap.
      ready = 1'b0;
      cnt_in = 4'd3; push(35, 3); push(37, 2);
      wait_valid("wv_3");
      cyc(3);
      chk("bp_held_valid", 32'(bus.out_valid),  32'd1);
      chk("bp_held_data",  32'(bus.out_data),   32'd35);
      chk("bp_held_data5", 32'(bus5.out_data),  32'd3);
      cnt_in = 4'd5;
      cyc(6);
      chk("bp_hold_data",  32'(bus.out_data),   32'd35);
      chk("bp_hold_delta", 32'(bus.out_delta),  32'd3);
      ready = 1'b1;
      cyc(1);
      chk("bp_no_gap",     32'(bus.out_valid),  32'd1);
      chk("bp_rel_data",   32'(bus.out_data),   32'd37);
      chk("bp_rel_delta",  32'(bus.out_delta),  32'd2);
      chk("bp_rel_data5",  32'(bus5.out_data),  32'd5);
      cyc(1);
      chk("bp_idle", 32'(bus.out_valid), 32'd0);
`ifdef RCC_CAPTURE_OVF_EN
      chk("ovf5_sticky", 32'(ovf5), 32'd1);
`endif

      // Mid-handshake reset: the stalled record is lost.
      ready = 1'b0;
      cnt_in = 4'd9;
      wait_valid("wv_9");
      reset = 1'b0;
      cnt_in = 4'd6;
      cyc(1);
      reset = 1'b1;
      chk("mrst_valid", 32'(bus.out_valid),  32'd0);
      chk("mrst_data",  32'(bus.out_data),   32'd0);
      chk("mrst_delta", 32'(bus.out_delta),  32'd0);
`ifdef RCC_CAPTURE_OVF_EN
      chk("mrst_ovf5", 32'(ovf5), 32'd0);
`endif
      ready = 1'b1;
      push(6, 6);
      wait_valid("wv_6");
      cyc(1);
      chk("mrst_pulse", 32'(bus.out_valid), 32'd0);

      cyc(2);
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
